// File: rtl/mdu_pkg.sv
// Shared encodings, state codes and default latencies for the multiply/divide unit.
// Constants only: no latency, no flow control.
package mdu_pkg;

   localparam logic [1:0] MDU_MULT  = 2'b00;
   localparam logic [1:0] MDU_MULTU = 2'b01;
   localparam logic [1:0] MDU_DIV   = 2'b10;
   localparam logic [1:0] MDU_DIVU  = 2'b11;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;
   localparam int CNT_W           = 5;

   // Divides are the ops with the high encoding bit set.
   function automatic logic isDiv(input logic [1:0] code);
      return code[1];
   endfunction

   // The counter is loaded with N-1 so busy spans exactly N cycles.
   function automatic logic [CNT_W-1:0] loadCount(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational mult/div datapath producing the 64-bit {hi,lo} result from latched operands.
// Zero latency; no flow control (sampled by the controller at commit).
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [1:0]  op,
   input  logic [31:0] opA,
   input  logic [31:0] opB,
   output logic [31:0] hiRes,
   output logic [31:0] loRes
);

   logic        signedDiv;
   logic        negQuo;
   logic        negRem;
   logic [31:0] magA;
   logic [31:0] magB;
   logic [31:0] divisor;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [63:0] prodS;
   logic [63:0] prodU;

   // Low 64 bits of a product of sign-extended operands equal the signed product.
   assign prodS = {{32{opA[31]}}, opA} * {{32{opB[31]}}, opB};
   assign prodU = {32'd0, opA} * {32'd0, opB};

   assign signedDiv = (op == MDU_DIV);
   assign negQuo    = signedDiv & (opA[31] ^ opB[31]);
   assign negRem    = signedDiv & opA[31];
   assign magA      = (signedDiv & opA[31]) ? -opA : opA;
   assign magB      = (signedDiv & opB[31]) ? -opB : opB;
   assign divisor   = (magB == '0) ? 32'd1 : magB;
   assign quo       = magA / divisor;
   assign rem       = magA % divisor;

   always_comb begin
      hiRes = '0;
      loRes = '0;
      case (op)
         MDU_MULT:  {hiRes, loRes} = prodS;
         MDU_MULTU: {hiRes, loRes} = prodU;
         MDU_DIV, MDU_DIVU: begin
            if (opB == '0) begin
               loRes = 32'hFFFF_FFFF;
               hiRes = opA;
            end else if (signedDiv && opA == 32'h8000_0000 && opB == 32'hFFFF_FFFF) begin
               loRes = 32'h8000_0000;
               hiRes = 32'h0000_0000;
            end else begin
               loRes = negQuo ? -quo : quo;
               hiRes = negRem ? -rem : rem;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_controller.sv
// MDU sequencer owning HI/LO: busy for MULT_CYCLES/DIV_CYCLES after issue, commits with a done pulse.
// No backpressure on issue; stall_req holds ID while occupied. MDU_CANCEL_EN adds a cancel input.
module mdu_controller
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] opA,
   input  logic [31:0] opB,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   input  logic        md_use_D,
`ifdef MDU_CANCEL_EN
   input  logic        cancel,
`endif
   output logic        busy,
   output logic        done,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [CNT_W-1:0] MULT_LOAD = loadCount(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = loadCount(DIV_CYCLES);

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       opLat;
   logic [31:0]      opALat;
   logic [31:0]      opBLat;
   logic [31:0]      hiRes;
   logic [31:0]      loRes;
   logic             cancelNow;
   logic             launch;
   logic             commit;
   logic             moveOk;

`ifdef MDU_CANCEL_EN
   assign cancelNow = cancel;
`else
   assign cancelNow = 1'b0;
`endif

   // Cancel outranks both a fresh issue and the final commit.
   assign launch = (state == IDLE) & start & ~cancelNow;
   assign commit = (state == BUSY) & (cnt == '0) & ~cancelNow;
   assign moveOk = (state == IDLE) & ~start;

   mdu_arith uArith (
      .op    (opLat),
      .opA   (opALat),
      .opB   (opBLat),
      .hiRes (hiRes),
      .loRes (loRes)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         done   <= 1'b0;
         opLat  <= '0;
         opALat <= '0;
         opBLat <= '0;
      end else begin
         done <= commit;
         if (launch) begin
            state  <= BUSY;
            cnt    <= isDiv(op) ? DIV_LOAD : MULT_LOAD;
            opLat  <= op;
            opALat <= opA;
            opBLat <= opB;
         end else if (state == BUSY) begin
            if (cancelNow || cnt == '0) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               cnt <= cnt - CNT_W'(1);
            end
         end
      end
   end

   // Moves only land in IDLE without a competing issue; in BUSY the hazard stall keeps them out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         hi <= hiRes;
         lo <= loRes;
      end else if (moveOk) begin
         if (mthi) hi <= wdata;
         if (mtlo) lo <= wdata;
      end
   end

   assign busy      = (state == BUSY);
   assign stall_req = md_use_D & (busy | start);

endmodule

// File: tb/tb_mdu_controller.sv
// Scoreboard bench for mdu_controller: expected HI/LO queued at issue, compared at done.
module tb_mdu_controller;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = '0;
   logic [31:0] opA = '0;
   logic [31:0] opB = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [31:0] wdata = '0;
   logic        md_use_D = 1'b0;
`ifdef MDU_CANCEL_EN
   logic        cancel = 1'b0;
`endif
   logic        busy;
   logic        done;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   int          checks = 0;
   int          errors = 0;
   int          doneCount = 0;
   logic [31:0] curHi = '0;
   logic [31:0] curLo = '0;
   logic [63:0] expQ[$];

   mdu_controller dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .opA       (opA),
      .opB       (opB),
      .mthi      (mthi),
      .mtlo      (mtlo),
      .wdata     (wdata),
      .md_use_D  (md_use_D),
`ifdef MDU_CANCEL_EN
      .cancel    (cancel),
`endif
      .busy      (busy),
      .done      (done),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) doneCount++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: begin q = sa * sb; return q; end
         2'b01: return {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
      start = 1'b1; op = o; opA = a; opB = b;
      expQ.push_back(exp);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int expBusy, input string name);
      int n;
      bit seen;
      logic [63:0] exp;
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin seen = 1'b1; break; end
         if (busy === 1'b1) n++;
      end
      exp = (expQ.size() != 0) ? expQ.pop_front() : 64'hx;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: done=0 after 64 cycles, required done=1", name);
      end else begin
         checks++;
         if (n != expBusy) begin
            errors++;
            $display("FAIL %s_latency: busy cycles %0d, required %0d", name, n, expBusy);
         end
         checks++;
         if ({hi, lo} !== exp) begin
            errors++;
            $display("FAIL %s_result: hi/lo %h, required %h", name, {hi, lo}, exp);
         end
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_at_done: busy %b, required 0", name, busy);
         end
      end
      curHi = exp[63:32];
      curLo = exp[31:0];
   endtask

   task automatic test_reset();
      md_use_D = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: %b, required 0", done); end
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: %h, required 0", hi); end
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: %h, required 0", lo); end
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: %b, required 0", stall_req); end
      md_use_D = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mult();
      issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
      wait_done(5, "mult");
   endtask

   task automatic test_div();
      issue(MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
      wait_done(10, "divu");
      issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      wait_done(10, "div_signed");
      issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
      wait_done(10, "div_overflow");
   endtask

   task automatic test_div_zero();
      int d0;
      @(posedge clk); #1;
      d0 = doneCount;
      issue(MDU_DIV, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF});
      wait_done(10, "div_zero");
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (doneCount !== d0 + 1) begin
         errors++;
         $display("FAIL div_zero_done_count: %0d pulses, required 1", doneCount - d0);
      end
   endtask

   task automatic test_stall();
      logic [63:0] exp;
      @(posedge clk); #1;
      md_use_D = 1'b1;
      start = 1'b1; op = MDU_MULT; opA = 32'd5; opB = 32'd6;
      expQ.push_back({32'd0, 32'd30});
      @(negedge clk);
      checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL stall_start_cycle: %b, required 1", stall_req); end
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (stall_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_busy_cycle%0d: stall %b busy %b, required 1 1", i, stall_req, busy);
         end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || stall_req !== 1'b0) begin
         errors++;
         $display("FAIL stall_done_cycle: done %b stall %b, required 1 0", done, stall_req);
      end
      exp = expQ.pop_front();
      checks++;
      if ({hi, lo} !== exp) begin errors++; $display("FAIL stall_result: %h, required %h", {hi, lo}, exp); end
      curHi = exp[63:32];
      curLo = exp[31:0];
      md_use_D = 1'b0;
   endtask

   task automatic test_moves();
      @(posedge clk); #1;
      mthi = 1'b1; wdata = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      mthi = 1'b0;
      @(negedge clk);
      checks++; if (hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi: hi %h, required a5a5a5a5", hi); end
      curHi = 32'hA5A5_A5A5;
      mtlo = 1'b1; wdata = 32'h5A5A_5A5A;
      @(posedge clk); #1;
      mtlo = 1'b0;
      @(negedge clk);
      checks++; if (lo !== 32'h5A5A_5A5A) begin errors++; $display("FAIL mtlo: lo %h, required 5a5a5a5a", lo); end
      checks++; if (hi !== curHi) begin errors++; $display("FAIL mtlo_hi_kept: hi %h, required %h", hi, curHi); end
      curLo = 32'h5A5A_5A5A;
   endtask

   task automatic test_mtlo_busy();
      issue(MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
      mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      mtlo = 1'b0;
      @(negedge clk);
      checks++; if (lo !== curLo) begin errors++; $display("FAIL mtlo_busy: lo %h, required %h", lo, curLo); end
      wait_done(8, "mtlo_busy");
   endtask

   task automatic test_start_mthi();
      @(posedge clk); #1;
      start = 1'b1; op = MDU_MULT; opA = 32'd2; opB = 32'd3;
      expQ.push_back({32'd0, 32'd6});
      mthi = 1'b1; wdata = 32'hFFFF_0000;
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0;
      @(negedge clk);
      checks++; if (hi !== curHi) begin errors++; $display("FAIL start_mthi_dropped: hi %h, required %h", hi, curHi); end
      wait_done(4, "start_mthi");
   endtask

   task automatic test_start_busy();
      int d0;
      @(posedge clk); #1;
      d0 = doneCount;
      issue(MDU_MULT, 32'd7, 32'd7, {32'd0, 32'd49});
      start = 1'b1; op = MDU_DIVU; opA = 32'd1000; opB = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(4, "start_busy");
      repeat (15) @(posedge clk);
      #1;
      checks++;
      if (doneCount !== d0 + 1) begin
         errors++;
         $display("FAIL start_busy_done_count: %0d pulses, required 1", doneCount - d0);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pool [4];
      pool = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) begin
         o = (k < 4) ? 2'(k) : 2'($urandom_range(0, 3));
         a = (k == 2) ? 32'h8000_0000 : $urandom;
         b = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
         issue(o, a, b, model(o, a, b));
         wait_done(o[1] ? 10 : 5, "b2b");
      end
   endtask

`ifdef MDU_CANCEL_EN
   task automatic test_cancel();
      int d0;
      @(posedge clk); #1;
      d0 = doneCount;
      issue(MDU_MULT, 32'd9, 32'd9, {32'd0, 32'd81});
      void'(expQ.pop_back());
      @(posedge clk); #1;
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: %b, required 0", busy); end
      checks++;
      if ({hi, lo} !== {curHi, curLo}) begin
         errors++;
         $display("FAIL cancel_hilo: %h, required %h", {hi, lo}, {curHi, curLo});
      end
      repeat (10) @(posedge clk);
      #1;
      checks++; if (doneCount !== d0) begin errors++; $display("FAIL cancel_no_done: %0d pulses, required 0", doneCount - d0); end
      start = 1'b1; cancel = 1'b1; op = MDU_MULT; opA = 32'd2; opB = 32'd2;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_start_suppressed: busy %b, required 0", busy); end
   endtask
`endif

   task automatic test_reset_mid();
      int d0;
      @(posedge clk); #1;
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1357_9BDF;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
      issue(MDU_DIV, 32'd50, 32'd5, {32'd0, 32'd10});
      expQ.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: %b, required 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_mid_done: %b, required 0", done); end
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_mid_hi: %h, required 0", hi); end
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_mid_lo: %h, required 0", lo); end
      d0 = doneCount;
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      checks++; if (doneCount !== d0) begin errors++; $display("FAIL reset_mid_no_done: %0d pulses, required 0", doneCount - d0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: busy %b, required 0", busy); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_stall();
      test_moves();
      test_mtlo_busy();
      test_start_mthi();
      test_start_busy();
      test_back_to_back();
`ifdef MDU_CANCEL_EN
      test_cancel();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
